// File: rtl/gpio_reg_arbiter.sv
// gpio_reg_arbiter: a single-port register array shared by a host port and two
// internal ports (A, B). One access per cycle. The host normally wins, A/B share
// through a round-robin pointer, and a wait counter stops the host from starving
// pending internal requests.
module gpio_reg_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int WAIT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  rr;
    logic [WAIT_W-1:0]     wait_cnt;

    logic                  int_req;
    logic                  starved;
    logic                  host_win;
    logic                  a_pick;
    logic                  b_pick;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Arbitration: host first unless the internal side has waited MAX_WAIT host
    // wins; between A and B a lone requester always wins, otherwise rr decides.
    // Grants are forced low while reset is asserted.
    always_comb begin
        int_req  = a_req | b_req;
        starved  = (wait_cnt == WAIT_W'(MAX_WAIT));
        a_pick   = a_req & (~b_req | ~rr);
        b_pick   = b_req & (~a_req | rr);
        host_win = h_req & ~(starved & int_req);
        h_gnt    = rst_n & host_win;
        a_gnt    = rst_n & ~host_win & a_pick;
        b_gnt    = rst_n & ~host_win & b_pick;
    end

    // Steer the granted port's request onto the single array port.
    always_comb begin
        any_gnt   = h_gnt | a_gnt | b_gnt;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (h_gnt) begin
            sel_we    = h_we;
            sel_addr  = h_addr;
            sel_wdata = h_wdata;
        end else if (a_gnt) begin
            sel_we    = a_we;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
        end else if (b_gnt) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Register array: cleared by reset, written by whichever port holds the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (any_gnt && sel_we) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Per-port read returns: one-cycle rvalid pulse, rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rvalid <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            h_rdata  <= '0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            h_rvalid <= h_gnt & ~h_we;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (h_gnt && !h_we) h_rdata <= mem[h_addr];
            if (a_gnt && !a_we) a_rdata <= mem[a_addr];
            if (b_gnt && !b_we) b_rdata <= mem[b_addr];
        end
    end

    // Fairness state: rr points away from the last internal winner; wait_cnt
    // counts host wins that overtook a pending internal request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= 1'b0;
            wait_cnt <= '0;
        end else if (a_gnt || b_gnt) begin
            rr       <= a_gnt;
            wait_cnt <= '0;
        end else if (!int_req) begin
            wait_cnt <= '0;
        end else if (h_gnt && !starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// tb_gpio_reg_arbiter: directed scenarios followed by random traffic, all checked
// against a behavioural model of the arbiter and register array.
module tb_gpio_reg_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int MW   = 4;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          req_s   [3];
    logic          we_s    [3];
    logic [AW-1:0] addr_s  [3];
    logic [DW-1:0] wdata_s [3];

    logic          h_gnt, a_gnt, b_gnt;
    logic          h_rvalid, a_rvalid, b_rvalid;
    logic [DW-1:0] h_rdata, a_rdata, b_rdata;

    logic [DW-1:0] mem_m  [NREG];
    int            rr_m;
    int            wait_m;
    logic          exp_rv [3];
    logic [DW-1:0] exp_rd [3];

    int            vectors     = 0;
    int            miscompares = 0;

    logic [2:0]    g;
    int            w;

    gpio_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_req    (req_s[0]),
        .h_we     (we_s[0]),
        .h_addr   (addr_s[0]),
        .h_wdata  (wdata_s[0]),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .a_req    (req_s[1]),
        .a_we     (we_s[1]),
        .a_addr   (addr_s[1]),
        .a_wdata  (wdata_s[1]),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (req_s[2]),
        .b_we     (we_s[2]),
        .b_addr   (addr_s[2]),
        .b_wdata  (wdata_s[2]),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_s[p]   = r;
        we_s[p]    = we;
        addr_s[p]  = a;
        wdata_s[p] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem_m[i] = '0;
        rr_m   = 0;
        wait_m = 0;
        for (int p = 0; p < 3; p++) begin
            exp_rv[p] = 1'b0;
            exp_rd[p] = '0;
        end
    endtask

    // Who should win this cycle: -1 none, 0 host, 1 A, 2 B.
    function automatic int model_winner();
        int  internal;
        bit  pend;
        pend = req_s[1] || req_s[2];
        if (req_s[1] && req_s[2]) internal = (rr_m == 0) ? 1 : 2;
        else if (req_s[1])        internal = 1;
        else if (req_s[2])        internal = 2;
        else                      internal = -1;
        if (pend && wait_m >= MW) return internal;
        if (req_s[0])             return 0;
        return internal;
    endfunction

    // Apply the effect of the access performed at the clock edge.
    task automatic model_update(input int win);
        bit pend;
        pend = req_s[1] || req_s[2];
        for (int p = 0; p < 3; p++) exp_rv[p] = 1'b0;
        if (win >= 0) begin
            if (we_s[win]) begin
                mem_m[addr_s[win]] = wdata_s[win];
            end else begin
                exp_rv[win] = 1'b1;
                exp_rd[win] = mem_m[addr_s[win]];
            end
        end
        if (win == 1 || win == 2) begin
            rr_m   = (win == 1) ? 1 : 0;
            wait_m = 0;
        end else if (!pend) begin
            wait_m = 0;
        end else if (win == 0 && wait_m < MW) begin
            wait_m = wait_m + 1;
        end
    endtask

    task automatic check_output();
        check("h_rvalid", h_rvalid, exp_rv[0]);
        check("a_rvalid", a_rvalid, exp_rv[1]);
        check("b_rvalid", b_rvalid, exp_rv[2]);
        check("h_rdata",  h_rdata,  exp_rd[0]);
        check("a_rdata",  a_rdata,  exp_rd[1]);
        check("b_rdata",  b_rdata,  exp_rd[2]);
    endtask

    // One cycle: inputs already driven at the falling edge; check grants, clock,
    // then check read returns at the next falling edge.
    task automatic apply_stimulus(output logic [2:0] gcode, output int win);
        #1;
        win   = model_winner();
        gcode = {b_gnt, a_gnt, h_gnt};
        check("h_gnt", h_gnt, win == 0);
        check("a_gnt", a_gnt, win == 1);
        check("b_gnt", b_gnt, win == 2);
        @(posedge clk);
        model_update(win);
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        model_reset();
        for (int p = 0; p < 3; p++) req_s[p] = 1'b1;
        #1;
        check("rst_gnt", {b_gnt, a_gnt, h_gnt}, 3'b000);
        check_output();
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_all();
        #1;
        do_reset();

        // Host write then read of addr 3.
        set_port(0, 1'b1, 1'b1, 5'd3, 16'hA5A5);
        apply_stimulus(g, w);
        check("r28_wr_gnt", g, 3'b001);
        set_port(0, 1'b1, 1'b0, 5'd3, 16'h0000);
        apply_stimulus(g, w);
        check("r28_rd_gnt", g, 3'b001);
        check("r28_rvalid", h_rvalid, 1'b1);
        check("r28_rdata", h_rdata, 16'hA5A5);
        check("r28_ab_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        idle_all();
        apply_stimulus(g, w);
        check("r28_rvalid_drop", h_rvalid, 1'b0);
        check("r28_rdata_hold", h_rdata, 16'hA5A5);

        // A and B both request continuously: strict alternation from A.
        do_reset();
        set_port(1, 1'b1, 1'b0, 5'd1, 16'h0);
        set_port(2, 1'b1, 1'b0, 5'd2, 16'h0);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(g, w);
            check("r29_alt", g, (i % 2 == 0) ? 3'b010 : 3'b100);
        end

        // Host and A continuously: four host grants then one A grant.
        idle_all();
        set_port(0, 1'b1, 1'b0, 5'd3, 16'h0);
        set_port(1, 1'b1, 1'b0, 5'd4, 16'h0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(g, w);
            check("r30_pattern", g, (i % 5 == 4) ? 3'b010 : 3'b001);
        end

        // A writes top address, B reads it back the next cycle.
        idle_all();
        set_port(1, 1'b1, 1'b1, 5'd31, 16'h1234);
        apply_stimulus(g, w);
        check("r31_a_gnt", g, 3'b010);
        idle_all();
        set_port(2, 1'b1, 1'b0, 5'd31, 16'h0);
        apply_stimulus(g, w);
        check("r31_b_gnt", g, 3'b100);
        check("r31_b_rdata", b_rdata, 16'h1234);

        // Reset dropped during a host write: write aborted, returns cleared.
        idle_all();
        set_port(0, 1'b1, 1'b1, 5'd0, 16'h5555);
        apply_stimulus(g, w);
        set_port(0, 1'b1, 1'b1, 5'd0, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("r32_gnt_in_rst", h_gnt, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("r32_rvalid", {h_rvalid, a_rvalid, b_rvalid}, 3'b000);
        idle_all();
        model_reset();
        rst_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 5'd0, 16'h0);
        apply_stimulus(g, w);
        check("r32_rdata", h_rdata, 16'h0000);

        // All three request after reset: H, then A, then B.
        do_reset();
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 5'(p + 7), 16'h0);
        apply_stimulus(g, w);
        check("r33_first", g, 3'b001);
        req_s[0] = 1'b0;
        apply_stimulus(g, w);
        check("r33_second", g, 3'b010);
        req_s[1] = 1'b0;
        apply_stimulus(g, w);
        check("r33_third", g, 3'b100);

        // Random traffic; each requester holds its request until granted.
        idle_all();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (!req_s[p] && $urandom_range(0, 2) != 0) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, NREG - 1)), 16'($urandom));
                end
            end
            apply_stimulus(g, w);
            if (w >= 0) req_s[w] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
